// File: rtl/irq_ctrl_pkg.sv
// Shared constants for the interrupt controller: register map, FSM encoding, CAUSE layout.
package irq_ctrl_pkg;

   localparam int unsigned N_SRC_DEF = 8;
   localparam int unsigned ID_W_DEF  = 3;

   localparam logic [1:0] IRQ_REG_MASK  = 2'd0;
   localparam logic [1:0] IRQ_REG_PEND  = 2'd1;
   localparam logic [1:0] IRQ_REG_CAUSE = 2'd2;
   localparam logic [1:0] IRQ_REG_RSVD  = 2'd3;

   typedef enum logic [1:0] {
      IRQ_IDLE = 2'd0,
      IRQ_REQ  = 2'd1,
      IRQ_SVC  = 2'd2
   } irq_state_e;

   localparam int unsigned CAUSE_BUSY_BIT  = 31;
   localparam int unsigned CAUSE_VALID_BIT = 8;

endpackage

// File: rtl/irq_ctrl_if.sv
// Source lines, config bus and CP0 handshake of the interrupt controller.
interface irq_ctrl_if
   import irq_ctrl_pkg::*;
#(
   parameter int unsigned N_SRC = N_SRC_DEF,
   parameter int unsigned ID_W  = ID_W_DEF
);
   logic [N_SRC-1:0] irq_src;
   logic             cfg_we;
   logic [1:0]       cfg_addr;
   logic [31:0]      cfg_wdata;
   logic [31:0]      cfg_rdata;
   logic             irq_out;
   logic [ID_W-1:0]  irq_id;
   logic             irq_ack;
   logic             eret;

   modport master (
      output irq_src, cfg_we, cfg_addr, cfg_wdata, irq_ack, eret,
      input  cfg_rdata, irq_out, irq_id
   );

   modport slave (
      input  irq_src, cfg_we, cfg_addr, cfg_wdata, irq_ack, eret,
      output cfg_rdata, irq_out, irq_id
   );
endinterface

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: lowest set index wins; o_any flags a non-zero vector.
module irq_prio_enc
   import irq_ctrl_pkg::*;
#(
   parameter int unsigned N_SRC = N_SRC_DEF,
   parameter int unsigned ID_W  = ID_W_DEF
) (
   input  logic [N_SRC-1:0] i_vec,
   output logic [ID_W-1:0]  o_id,
   output logic             o_any
);

   always_comb begin
      o_id  = '0;
      o_any = |i_vec;
      // Scan downwards so the lowest set index is the last assignment.
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (i_vec[i]) begin
            o_id = ID_W'(i);
         end
      end
   end

endmodule

// File: rtl/irq_ctrl.sv
// Edge-latching, maskable, fixed-priority interrupt controller with auto-EOI on ERET.
module irq_ctrl
   import irq_ctrl_pkg::*;
#(
   parameter int unsigned N_SRC = N_SRC_DEF,
   parameter int unsigned ID_W  = ID_W_DEF
) (
   input logic       clk,
   input logic       rst,
   irq_ctrl_if.slave io_bus
);

   logic [N_SRC-1:0] r_src_d;
   logic [N_SRC-1:0] r_mask;
   logic [N_SRC-1:0] r_pend;
   irq_state_e       r_state;
   logic [ID_W-1:0]  r_irq_id;
   logic             r_irq_out;

   logic [N_SRC-1:0] w_edge;
   logic [N_SRC-1:0] w_eligible;
   logic [N_SRC-1:0] w_mask_d;
   logic [N_SRC-1:0] w_pend_d;
   logic [N_SRC-1:0] w_elig_next;
   logic             w_wr_mask;
   logic             w_wr_pend;
   logic             w_eoi;
   logic [ID_W-1:0]  w_win_id;
   logic             w_any;
   irq_state_e       w_state_d;
   logic [ID_W-1:0]  w_id_d;
   logic [31:0]      w_cause;

   assign w_edge     = io_bus.irq_src & ~r_src_d;
   assign w_eligible = r_pend & r_mask;
   assign w_wr_mask  = io_bus.cfg_we && (io_bus.cfg_addr == IRQ_REG_MASK);
   assign w_wr_pend  = io_bus.cfg_we && (io_bus.cfg_addr == IRQ_REG_PEND);
   assign w_eoi      = (r_state == IRQ_SVC) && io_bus.eret;

   irq_prio_enc #(
      .N_SRC (N_SRC),
      .ID_W  (ID_W)
   ) u_prio_enc (
      .i_vec (w_eligible),
      .o_id  (w_win_id),
      .o_any (w_any)
   );

   always_comb begin
      w_mask_d = r_mask;
      if (w_wr_mask) begin
         w_mask_d = io_bus.cfg_wdata[N_SRC-1:0];
      end
   end

   // Clears (W1C, auto-EOI) are applied first so that a same-cycle edge wins.
   always_comb begin
      w_pend_d = r_pend;
      if (w_wr_pend) begin
         w_pend_d = w_pend_d & ~io_bus.cfg_wdata[N_SRC-1:0];
      end
      if (w_eoi) begin
         w_pend_d[r_irq_id] = 1'b0;
      end
      w_pend_d = w_pend_d | w_edge;
   end

   assign w_elig_next = w_pend_d & w_mask_d;

   always_comb begin
      w_state_d = r_state;
      w_id_d    = r_irq_id;
      case (r_state)
         IRQ_IDLE: begin
            if (w_any) begin
               w_state_d = IRQ_REQ;
               w_id_d    = w_win_id;
            end
         end
         IRQ_REQ: begin
            if (io_bus.irq_ack) begin
               w_state_d = IRQ_SVC;
            end else if (!w_elig_next[r_irq_id]) begin
               w_state_d = IRQ_IDLE;
            end
         end
         IRQ_SVC: begin
            if (io_bus.eret) begin
               w_state_d = IRQ_IDLE;
            end
         end
         default: w_state_d = IRQ_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_src_d   <= '0;
         r_mask    <= '0;
         r_pend    <= '0;
         r_state   <= IRQ_IDLE;
         r_irq_id  <= '0;
         r_irq_out <= 1'b0;
      end else begin
         r_src_d   <= io_bus.irq_src;
         r_mask    <= w_mask_d;
         r_pend    <= w_pend_d;
         r_state   <= w_state_d;
         r_irq_id  <= w_id_d;
         r_irq_out <= (w_state_d == IRQ_REQ);
      end
   end

   always_comb begin
      w_cause                  = '0;
      w_cause[CAUSE_BUSY_BIT]  = (r_state != IRQ_IDLE);
      w_cause[CAUSE_VALID_BIT] = (r_state == IRQ_REQ) || (r_state == IRQ_SVC);
      w_cause[ID_W-1:0]        = r_irq_id;
   end

   always_comb begin
      io_bus.cfg_rdata = '0;
      case (io_bus.cfg_addr)
         IRQ_REG_MASK:  io_bus.cfg_rdata = 32'(r_mask);
         IRQ_REG_PEND:  io_bus.cfg_rdata = 32'(r_pend);
         IRQ_REG_CAUSE: io_bus.cfg_rdata = w_cause;
         IRQ_REG_RSVD:  io_bus.cfg_rdata = '0;
         default:       io_bus.cfg_rdata = '0;
      endcase
   end

   assign io_bus.irq_out = r_irq_out;
   assign io_bus.irq_id  = r_irq_id;

endmodule
